// File: rtl/ctrl_pipe_hazard_if.sv
// Control-pipeline bundle: decoded ID-stage control, flush request, and the
// per-stage pipeline register contents with hazard status.
interface ctrl_pipe_hazard_if #(
    parameter int unsigned REGW = 5,
    parameter int unsigned CNTW = 16
);
    logic            ID_ALUSrc;
    logic            ID_MemToReg;
    logic            ID_RegWrite;
    logic            ID_MemRead;
    logic            ID_MemWrite;
    logic            ID_Branch;
    logic            ID_Uncondbranch;
    logic            ID_CNBZSig;
    logic            ID_BL;
    logic [1:0]      ID_ALUOp;
    logic [REGW-1:0] ID_Rn;
    logic [REGW-1:0] ID_Rm;
    logic [REGW-1:0] ID_Rd;
    logic            ID_UseRn;
    logic            ID_UseRm;
    logic            Flush;

    logic            Stall;

    logic            EX_ALUSrc;
    logic            EX_Branch;
    logic            EX_Uncondbranch;
    logic            EX_CNBZSig;
    logic            EX_MemRead;
    logic            EX_MemWrite;
    logic            EX_MemToReg;
    logic            EX_RegWrite;
    logic            EX_BL;
    logic [1:0]      EX_ALUOp;
    logic [REGW-1:0] EX_Rd;

    logic            MEM_Branch;
    logic            MEM_Uncondbranch;
    logic            MEM_CNBZSig;
    logic            MEM_MemRead;
    logic            MEM_MemWrite;
    logic            MEM_MemToReg;
    logic            MEM_RegWrite;
    logic            MEM_BL;
    logic [REGW-1:0] MEM_Rd;

    logic            WB_MemToReg;
    logic            WB_RegWrite;
    logic            WB_BL;
    logic [REGW-1:0] WB_Rd;

    logic [CNTW-1:0] StallCount;

    modport master (
        output ID_ALUSrc, ID_MemToReg, ID_RegWrite, ID_MemRead, ID_MemWrite,
               ID_Branch, ID_Uncondbranch, ID_CNBZSig, ID_BL, ID_ALUOp,
               ID_Rn, ID_Rm, ID_Rd, ID_UseRn, ID_UseRm, Flush,
        input  Stall,
               EX_ALUSrc, EX_Branch, EX_Uncondbranch, EX_CNBZSig, EX_MemRead,
               EX_MemWrite, EX_MemToReg, EX_RegWrite, EX_BL, EX_ALUOp, EX_Rd,
               MEM_Branch, MEM_Uncondbranch, MEM_CNBZSig, MEM_MemRead, MEM_MemWrite,
               MEM_MemToReg, MEM_RegWrite, MEM_BL, MEM_Rd,
               WB_MemToReg, WB_RegWrite, WB_BL, WB_Rd, StallCount
    );

    modport slave (
        input  ID_ALUSrc, ID_MemToReg, ID_RegWrite, ID_MemRead, ID_MemWrite,
               ID_Branch, ID_Uncondbranch, ID_CNBZSig, ID_BL, ID_ALUOp,
               ID_Rn, ID_Rm, ID_Rd, ID_UseRn, ID_UseRm, Flush,
        output Stall,
               EX_ALUSrc, EX_Branch, EX_Uncondbranch, EX_CNBZSig, EX_MemRead,
               EX_MemWrite, EX_MemToReg, EX_RegWrite, EX_BL, EX_ALUOp, EX_Rd,
               MEM_Branch, MEM_Uncondbranch, MEM_CNBZSig, MEM_MemRead, MEM_MemWrite,
               MEM_MemToReg, MEM_RegWrite, MEM_BL, MEM_Rd,
               WB_MemToReg, WB_RegWrite, WB_BL, WB_Rd, StallCount
    );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// LEGv8 control pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall detection,
// branch-flush squashing and a saturating stall-cycle counter.
module ctrl_pipe_hazard #(
    parameter int unsigned REGW = 5,
    parameter int unsigned ZREG = 31,
    parameter int unsigned CNTW = 16
) (
    input  logic              CLK,
    input  logic              Reset_L,
    ctrl_pipe_hazard_if.slave bus
);

    localparam logic [REGW-1:0] ZREG_IDX = REGW'(ZREG);
    localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

    typedef struct packed {
        logic            alusrc;
        logic            branch;
        logic            uncondbranch;
        logic            cnbz;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            regwrite;
        logic            bl;
        logic [1:0]      aluop;
        logic [REGW-1:0] rd;
    } idex_t;

    typedef struct packed {
        logic            branch;
        logic            uncondbranch;
        logic            cnbz;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            regwrite;
        logic            bl;
        logic [REGW-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic            memtoreg;
        logic            regwrite;
        logic            bl;
        logic [REGW-1:0] rd;
    } memwb_t;

    idex_t           r_idex;
    exmem_t          r_exmem;
    memwb_t          r_memwb;
    logic [CNTW-1:0] r_stall_cnt;

    idex_t           w_idex_id;
    idex_t           w_idex_bub;
    exmem_t          w_exmem_ex;
    exmem_t          w_exmem_bub;
    memwb_t          w_memwb_mem;
    logic            w_stall;

    // Load in EX whose destination is read by the instruction in ID; XZR never conflicts.
    always_comb begin
        w_stall = r_idex.memread && (r_idex.rd != ZREG_IDX) &&
                  ((bus.ID_UseRn && (bus.ID_Rn == r_idex.rd)) ||
                   (bus.ID_UseRm && (bus.ID_Rm == r_idex.rd)));
    end

    // Next-value candidates for each pipeline register.
    always_comb begin
        w_idex_id              = '0;
        w_idex_id.alusrc       = bus.ID_ALUSrc;
        w_idex_id.branch       = bus.ID_Branch;
        w_idex_id.uncondbranch = bus.ID_Uncondbranch;
        w_idex_id.cnbz         = bus.ID_CNBZSig;
        w_idex_id.memread      = bus.ID_MemRead;
        w_idex_id.memwrite     = bus.ID_MemWrite;
        w_idex_id.memtoreg     = bus.ID_MemToReg;
        w_idex_id.regwrite     = bus.ID_RegWrite;
        w_idex_id.bl           = bus.ID_BL;
        w_idex_id.aluop        = bus.ID_ALUOp;
        w_idex_id.rd           = bus.ID_Rd;

        w_idex_bub             = '0;
        w_idex_bub.rd          = ZREG_IDX;

        w_exmem_ex              = '0;
        w_exmem_ex.branch       = r_idex.branch;
        w_exmem_ex.uncondbranch = r_idex.uncondbranch;
        w_exmem_ex.cnbz         = r_idex.cnbz;
        w_exmem_ex.memread      = r_idex.memread;
        w_exmem_ex.memwrite     = r_idex.memwrite;
        w_exmem_ex.memtoreg     = r_idex.memtoreg;
        w_exmem_ex.regwrite     = r_idex.regwrite;
        w_exmem_ex.bl           = r_idex.bl;
        w_exmem_ex.rd           = r_idex.rd;

        w_exmem_bub             = '0;
        w_exmem_bub.rd          = ZREG_IDX;

        w_memwb_mem             = '0;
        w_memwb_mem.memtoreg    = r_exmem.memtoreg;
        w_memwb_mem.regwrite    = r_exmem.regwrite;
        w_memwb_mem.bl          = r_exmem.bl;
        w_memwb_mem.rd          = r_exmem.rd;
    end

    // ID/EX: flush outranks stall; either inserts a bubble so decoder don't-cares never load.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_idex <= '0;
        end else if (bus.Flush || w_stall) begin
            r_idex <= w_idex_bub;
        end else begin
            r_idex <= w_idex_id;
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_exmem <= '0;
        end else if (bus.Flush) begin
            r_exmem <= w_exmem_bub;
        end else begin
            r_exmem <= w_exmem_ex;
        end
    end

    // The branch itself sits in MEM when it resolves, so MEM/WB is never squashed.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_memwb <= '0;
        end else begin
            r_memwb <= w_memwb_mem;
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !bus.Flush && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNTW'(1);
        end
    end

    assign bus.Stall            = w_stall;

    assign bus.EX_ALUSrc        = r_idex.alusrc;
    assign bus.EX_Branch        = r_idex.branch;
    assign bus.EX_Uncondbranch  = r_idex.uncondbranch;
    assign bus.EX_CNBZSig       = r_idex.cnbz;
    assign bus.EX_MemRead       = r_idex.memread;
    assign bus.EX_MemWrite      = r_idex.memwrite;
    assign bus.EX_MemToReg      = r_idex.memtoreg;
    assign bus.EX_RegWrite      = r_idex.regwrite;
    assign bus.EX_BL            = r_idex.bl;
    assign bus.EX_ALUOp         = r_idex.aluop;
    assign bus.EX_Rd            = r_idex.rd;

    assign bus.MEM_Branch       = r_exmem.branch;
    assign bus.MEM_Uncondbranch = r_exmem.uncondbranch;
    assign bus.MEM_CNBZSig      = r_exmem.cnbz;
    assign bus.MEM_MemRead      = r_exmem.memread;
    assign bus.MEM_MemWrite     = r_exmem.memwrite;
    assign bus.MEM_MemToReg     = r_exmem.memtoreg;
    assign bus.MEM_RegWrite     = r_exmem.regwrite;
    assign bus.MEM_BL           = r_exmem.bl;
    assign bus.MEM_Rd           = r_exmem.rd;

    assign bus.WB_MemToReg      = r_memwb.memtoreg;
    assign bus.WB_RegWrite      = r_memwb.regwrite;
    assign bus.WB_BL            = r_memwb.bl;
    assign bus.WB_Rd            = r_memwb.rd;

    assign bus.StallCount       = r_stall_cnt;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed bench for ctrl_pipe_hazard: reset, flow latency, load-use stall,
// false-hazard filtering, flush squashing, X suppression and counter saturation.
module tb_ctrl_pipe_hazard;

    localparam int unsigned REGW = 5;
    localparam int unsigned CNTW = 4;

    logic CLK;
    logic Reset_L;
    int   n_cmp;
    int   n_bad;
    int   exp_cnt;

    ctrl_pipe_hazard_if #(.REGW(REGW), .CNTW(CNTW)) bus ();

    ctrl_pipe_hazard #(.REGW(REGW), .ZREG(31), .CNTW(CNTW)) dut (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {ALUSrc,Branch,Uncond,CNBZ,MemRead,MemWrite,MemToReg,RegWrite,BL,ALUOp}
    function automatic logic [10:0] ex_vec();
        return {bus.EX_ALUSrc, bus.EX_Branch, bus.EX_Uncondbranch, bus.EX_CNBZSig,
                bus.EX_MemRead, bus.EX_MemWrite, bus.EX_MemToReg, bus.EX_RegWrite,
                bus.EX_BL, bus.EX_ALUOp};
    endfunction

    // {Branch,Uncond,CNBZ,MemRead,MemWrite,MemToReg,RegWrite,BL}
    function automatic logic [7:0] mem_vec();
        return {bus.MEM_Branch, bus.MEM_Uncondbranch, bus.MEM_CNBZSig, bus.MEM_MemRead,
                bus.MEM_MemWrite, bus.MEM_MemToReg, bus.MEM_RegWrite, bus.MEM_BL};
    endfunction

    function automatic logic [2:0] wb_vec();
        return {bus.WB_MemToReg, bus.WB_RegWrite, bus.WB_BL};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_nop();
        bus.ID_ALUSrc = 0; bus.ID_MemToReg = 0; bus.ID_RegWrite = 0;
        bus.ID_MemRead = 0; bus.ID_MemWrite = 0; bus.ID_Branch = 0;
        bus.ID_Uncondbranch = 0; bus.ID_CNBZSig = 0; bus.ID_BL = 0;
        bus.ID_ALUOp = 2'b00; bus.ID_Rn = '0; bus.ID_Rm = '0; bus.ID_Rd = '0;
        bus.ID_UseRn = 0; bus.ID_UseRm = 0; bus.Flush = 0;
    endtask

    task automatic set_ldur(input logic [REGW-1:0] rd);
        set_nop();
        bus.ID_ALUSrc = 1; bus.ID_MemRead = 1; bus.ID_MemToReg = 1;
        bus.ID_RegWrite = 1; bus.ID_Rd = rd;
    endtask

    task automatic set_add(input logic [REGW-1:0] rn, input logic [REGW-1:0] rm,
                           input logic urn, input logic urm, input logic [REGW-1:0] rd);
        set_nop();
        bus.ID_RegWrite = 1; bus.ID_ALUOp = 2'b10;
        bus.ID_Rn = rn; bus.ID_Rm = rm; bus.ID_UseRn = urn; bus.ID_UseRm = urm;
        bus.ID_Rd = rd;
    endtask

    task automatic test_reset();
        bus.ID_ALUSrc = 1; bus.ID_MemToReg = 1; bus.ID_RegWrite = 1;
        bus.ID_MemRead = 1; bus.ID_MemWrite = 1; bus.ID_Branch = 1;
        bus.ID_Uncondbranch = 1; bus.ID_CNBZSig = 1; bus.ID_BL = 1;
        bus.ID_ALUOp = 2'b11; bus.ID_Rn = 5'd31; bus.ID_Rm = 5'd31; bus.ID_Rd = 5'd7;
        bus.ID_UseRn = 1; bus.ID_UseRm = 1; bus.Flush = 0;
        step();
        step();
        n_cmp++;
        if (ex_vec() !== 11'h7FF) begin
            n_bad++; $display("FAIL reset_preload: ex=%h want %h", ex_vec(), 11'h7FF);
        end
        Reset_L = 0;
        #1;
        n_cmp++;
        if ({ex_vec(), bus.EX_Rd} !== '0) begin
            n_bad++; $display("FAIL reset_ex: ex=%h rd=%0d want 0", ex_vec(), bus.EX_Rd);
        end
        n_cmp++;
        if ({mem_vec(), bus.MEM_Rd, wb_vec(), bus.WB_Rd} !== '0) begin
            n_bad++; $display("FAIL reset_mem_wb: mem=%h rd=%0d wb=%h rd=%0d want 0",
                              mem_vec(), bus.MEM_Rd, wb_vec(), bus.WB_Rd);
        end
        n_cmp++;
        if ({bus.Stall, bus.StallCount} !== '0) begin
            n_bad++; $display("FAIL reset_stall: stall=%b cnt=%0d want 0", bus.Stall, bus.StallCount);
        end
        set_nop();
        step();
        Reset_L = 1;
        step();
    endtask

    task automatic test_flow();
        set_ldur(5'd5);
        step();
        set_nop();
        n_cmp++;
        if (ex_vec() !== 11'b10001011000 || bus.EX_Rd !== 5'd5) begin
            n_bad++; $display("FAIL flow_ex: ex=%b rd=%0d want 10001011000 rd=5", ex_vec(), bus.EX_Rd);
        end
        step();
        n_cmp++;
        if (mem_vec() !== 8'b00010110 || bus.MEM_Rd !== 5'd5) begin
            n_bad++; $display("FAIL flow_mem: mem=%b rd=%0d want 00010110 rd=5", mem_vec(), bus.MEM_Rd);
        end
        step();
        n_cmp++;
        if (wb_vec() !== 3'b110 || bus.WB_Rd !== 5'd5) begin
            n_bad++; $display("FAIL flow_wb: wb=%b rd=%0d want 110 rd=5", wb_vec(), bus.WB_Rd);
        end
    endtask

    task automatic test_load_use();
        set_ldur(5'd5);
        step();
        set_add(5'd5, 5'd2, 1, 1, 5'd6);
        #1;
        n_cmp++;
        if (bus.Stall !== 1'b1) begin
            n_bad++; $display("FAIL lu_stall: got %b want 1", bus.Stall);
        end
        step();
        exp_cnt = 1;
        n_cmp++;
        if (ex_vec() !== '0 || bus.EX_Rd !== 5'd31) begin
            n_bad++; $display("FAIL lu_bubble: ex=%b rd=%0d want 0 rd=31", ex_vec(), bus.EX_Rd);
        end
        n_cmp++;
        if (bus.StallCount !== CNTW'(exp_cnt) || bus.MEM_MemRead !== 1'b1) begin
            n_bad++; $display("FAIL lu_count: cnt=%0d memrd=%b want %0d 1", bus.StallCount, bus.MEM_MemRead, exp_cnt);
        end
        n_cmp++;
        if (bus.Stall !== 1'b0) begin
            n_bad++; $display("FAIL lu_release: stall=%b want 0", bus.Stall);
        end
        step();
        set_nop();
        n_cmp++;
        if (ex_vec() !== 11'b00000001010 || bus.EX_Rd !== 5'd6) begin
            n_bad++; $display("FAIL lu_add_ex: ex=%b rd=%0d want 00000001010 rd=6", ex_vec(), bus.EX_Rd);
        end
        set_ldur(5'd9);
        step();
        set_add(5'd1, 5'd9, 1, 1, 5'd8);
        #1;
        n_cmp++;
        if (bus.Stall !== 1'b1) begin
            n_bad++; $display("FAIL lu_rm_stall: got %b want 1", bus.Stall);
        end
        step();
        exp_cnt = 2;
        set_nop();
        n_cmp++;
        if (bus.StallCount !== CNTW'(exp_cnt)) begin
            n_bad++; $display("FAIL lu_rm_count: got %0d want %0d", bus.StallCount, exp_cnt);
        end
        step();
    endtask

    task automatic test_no_false_hazard();
        set_ldur(5'd31);
        step();
        set_add(5'd31, 5'd0, 1, 0, 5'd3);
        #1;
        n_cmp++;
        if (bus.Stall !== 1'b0) begin
            n_bad++; $display("FAIL nf_xzr: stall=%b want 0", bus.Stall);
        end
        set_ldur(5'd5);
        step();
        set_add(5'd3, 5'd5, 1, 0, 5'd4);
        #1;
        n_cmp++;
        if (bus.Stall !== 1'b0) begin
            n_bad++; $display("FAIL nf_unused_rm: stall=%b want 0", bus.Stall);
        end
        bus.ID_UseRm = 1;
        #1;
        n_cmp++;
        if (bus.Stall !== 1'b1) begin
            n_bad++; $display("FAIL nf_used_rm: stall=%b want 1", bus.Stall);
        end
        set_nop();
        step();
        step();
        n_cmp++;
        if (bus.StallCount !== CNTW'(exp_cnt)) begin
            n_bad++; $display("FAIL nf_count: got %0d want %0d", bus.StallCount, exp_cnt);
        end
    endtask

    task automatic test_flush();
        set_nop();
        bus.ID_Branch = 1; bus.ID_CNBZSig = 1; bus.ID_ALUOp = 2'b01; bus.ID_Rd = 5'd4;
        step();
        set_nop();
        bus.ID_MemWrite = 1; bus.ID_ALUSrc = 1; bus.ID_Rd = 5'd7;
        step();
        set_add(5'd1, 5'd2, 1, 1, 5'd8);
        n_cmp++;
        if (bus.MEM_Branch !== 1'b1 || bus.EX_MemWrite !== 1'b1) begin
            n_bad++; $display("FAIL fl_setup: mem_br=%b ex_mw=%b want 1 1", bus.MEM_Branch, bus.EX_MemWrite);
        end
        bus.Flush = 1;
        step();
        set_nop();
        n_cmp++;
        if (bus.MEM_MemWrite !== 1'b0 || bus.MEM_Rd !== 5'd31) begin
            n_bad++; $display("FAIL fl_mem: mw=%b rd=%0d want 0 31", bus.MEM_MemWrite, bus.MEM_Rd);
        end
        n_cmp++;
        if (bus.EX_RegWrite !== 1'b0 || ex_vec() !== '0 || bus.EX_Rd !== 5'd31) begin
            n_bad++; $display("FAIL fl_ex: ex=%b rd=%0d want 0 31", ex_vec(), bus.EX_Rd);
        end
        n_cmp++;
        if (bus.WB_Rd !== 5'd4 || wb_vec() !== 3'b000) begin
            n_bad++; $display("FAIL fl_wb: wb=%b rd=%0d want 000 4", wb_vec(), bus.WB_Rd);
        end
        set_ldur(5'd5);
        step();
        set_add(5'd5, 5'd0, 1, 0, 5'd6);
        bus.Flush = 1;
        #1;
        n_cmp++;
        if (bus.Stall !== 1'b1) begin
            n_bad++; $display("FAIL fl_stall_visible: stall=%b want 1", bus.Stall);
        end
        step();
        set_nop();
        n_cmp++;
        if (bus.StallCount !== CNTW'(exp_cnt) || bus.MEM_MemRead !== 1'b0 || bus.EX_Rd !== 5'd31) begin
            n_bad++; $display("FAIL fl_stall_count: cnt=%0d memrd=%b exrd=%0d want %0d 0 31",
                              bus.StallCount, bus.MEM_MemRead, bus.EX_Rd, exp_cnt);
        end
        step();
    endtask

    task automatic test_x_suppress();
        set_ldur(5'd5);
        step();
        set_add(5'd5, 5'd0, 1, 0, 5'd6);
        bus.ID_ALUSrc = 'x; bus.ID_MemToReg = 'x; bus.ID_RegWrite = 'x; bus.ID_MemRead = 'x;
        bus.ID_MemWrite = 'x; bus.ID_Branch = 'x; bus.ID_Uncondbranch = 'x;
        bus.ID_CNBZSig = 'x; bus.ID_BL = 'x; bus.ID_ALUOp = 'x;
        #1;
        n_cmp++;
        if (bus.Stall !== 1'b1) begin
            n_bad++; $display("FAIL x_stall: stall=%b want 1", bus.Stall);
        end
        step();
        exp_cnt++;
        set_nop();
        n_cmp++;
        if (ex_vec() !== '0 || bus.EX_Rd !== 5'd31) begin
            n_bad++; $display("FAIL x_bubble: ex=%b rd=%0d want 0 31", ex_vec(), bus.EX_Rd);
        end
        step();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            set_ldur(5'd5);
            step();
            set_add(5'd5, 5'd0, 1, 0, 5'd6);
            step();
            exp_cnt = (exp_cnt >= 15) ? 15 : exp_cnt + 1;
            n_cmp++;
            if (bus.StallCount !== CNTW'(exp_cnt)) begin
                n_bad++; $display("FAIL sat_iter%0d: cnt=%0d want %0d", i, bus.StallCount, exp_cnt);
            end
        end
        set_nop();
        step();
        n_cmp++;
        if (bus.StallCount !== 4'd15) begin
            n_bad++; $display("FAIL sat_final: cnt=%0d want 15", bus.StallCount);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_ldur(5'd5);
        step();
        set_add(5'd5, 5'd0, 1, 0, 5'd6);
        #1;
        n_cmp++;
        if (bus.Stall !== 1'b1) begin
            n_bad++; $display("FAIL rms_pre: stall=%b want 1", bus.Stall);
        end
        Reset_L = 0;
        #1;
        n_cmp++;
        if (bus.Stall !== 1'b0 || bus.StallCount !== '0 || bus.EX_MemRead !== 1'b0) begin
            n_bad++; $display("FAIL rms_post: stall=%b cnt=%0d exmr=%b want 0 0 0",
                              bus.Stall, bus.StallCount, bus.EX_MemRead);
        end
        set_nop();
        step();
        Reset_L = 1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        exp_cnt = 0;
        Reset_L = 0;
        set_nop();
        step();
        step();
        Reset_L = 1;
        step();
        test_reset();
        test_flow();
        test_load_use();
        test_no_false_hazard();
        test_flush();
        test_x_suppress();
        test_saturation();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
